// File: rtl/conv_controller.sv
// Sequencer for the KxK convolution datapath: loads weights, paces column beats,
// tracks window-completing shifts and queues the matching results.
//   IDLE   | waiting for start
//   LOAD_W | streaming K*K weights into the datapath
//   RUN    | accepting column beats under output-credit gating
//   DRAIN  | waiting for in-flight results and FIFO to empty
//   DONE   | one-cycle completion pulse
module conv_controller #(
  parameter int KERNEL_SIZE = 5,
  parameter int DATA_WIDTH  = 16,
  parameter int DIM_WIDTH   = 10,
  parameter int DP_LATENCY  = 2,
  parameter int OUT_DEPTH   = 4
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        start,
  input  logic [DIM_WIDTH-1:0]                        cfg_width,
  input  logic [DIM_WIDTH-1:0]                        cfg_height,
  input  logic [DATA_WIDTH-1:0]                       cfg_bias,
  output logic                                        busy,
  output logic                                        done,
  output logic                                        err,
  input  logic                                        w_valid,
  input  logic [DATA_WIDTH-1:0]                       w_data,
  output logic                                        w_ready,
  input  logic                                        col_valid,
  output logic                                        col_ready,
  output logic                                        dp_weight_write,
  output logic [$clog2(KERNEL_SIZE*KERNEL_SIZE)-1:0]  dp_weight_addr,
  output logic [DATA_WIDTH-1:0]                       dp_weight_data,
  output logic                                        dp_shift,
  output logic                                        dp_row_start,
  output logic [DATA_WIDTH-1:0]                       dp_bias,
  input  logic [DATA_WIDTH-1:0]                       dp_result,
  output logic                                        out_valid,
  output logic [DATA_WIDTH-1:0]                       out_data,
  input  logic                                        out_ready
);

  localparam int KK    = KERNEL_SIZE * KERNEL_SIZE;
  localparam int WA_W  = $clog2(KK);
  localparam int CNT_W = $clog2(OUT_DEPTH + 1);
  localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

  localparam logic [DIM_WIDTH-1:0] K_DIM    = DIM_WIDTH'(KERNEL_SIZE);
  localparam logic [DIM_WIDTH-1:0] K_M1     = DIM_WIDTH'(KERNEL_SIZE - 1);
  localparam logic [WA_W-1:0]      W_LAST   = WA_W'(KK - 1);
  localparam logic [CNT_W:0]       OCC_MAX  = (CNT_W + 1)'(OUT_DEPTH);
  localparam logic [PTR_W-1:0]     PTR_LAST = PTR_W'(OUT_DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [DIM_WIDTH-1:0]   width_q, width_d;
  logic [DIM_WIDTH-1:0]   height_q, height_d;
  logic [DIM_WIDTH-1:0]   col_q, col_d;
  logic [DIM_WIDTH-1:0]   band_q, band_d;
  logic [DATA_WIDTH-1:0]  bias_q, bias_d;
  logic [WA_W-1:0]        widx_q, widx_d;
  logic                   err_q, err_d;
  logic [DP_LATENCY-1:0]  vpipe_q, vpipe_d;
  logic [CNT_W-1:0]       inflight_q, inflight_d;
  logic [CNT_W-1:0]       fcnt_q, fcnt_d;
  logic [PTR_W-1:0]       wptr_q, wptr_d;
  logic [PTR_W-1:0]       rptr_q, rptr_d;
  logic [DATA_WIDTH-1:0]  mem_q [OUT_DEPTH];
  logic [DATA_WIDTH-1:0]  mem_d [OUT_DEPTH];

  logic            w_fire;
  logic            col_fire;
  logic            pipe_in;
  logic            push;
  logic            pop;
  logic [CNT_W:0]  occ;

  // Credit counts results already committed to the pipe, so a full FIFO can never be overrun.
  assign occ       = {1'b0, inflight_q} + {1'b0, fcnt_q};
  assign w_ready   = (state_q == S_LOAD_W);
  assign w_fire    = w_ready & w_valid;
  assign col_ready = (state_q == S_RUN) && (occ < OCC_MAX);
  assign col_fire  = col_ready & col_valid;
  assign pipe_in   = col_fire && (col_q >= K_M1);
  assign push      = vpipe_q[DP_LATENCY-1];
  assign pop       = out_valid & out_ready;

  assign dp_weight_write = w_fire;
  assign dp_weight_addr  = widx_q;
  assign dp_weight_data  = w_fire ? w_data : '0;
  assign dp_shift        = col_fire;
  assign dp_row_start    = col_fire && (col_q == '0);
  assign dp_bias         = bias_q;
  assign busy            = (state_q == S_LOAD_W) || (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done            = (state_q == S_DONE);
  assign err             = err_q;
  assign out_valid       = (fcnt_q != '0);
  assign out_data        = out_valid ? mem_q[rptr_q] : '0;

  always_comb begin
    state_d  = state_q;
    width_d  = width_q;
    height_d = height_q;
    col_d    = col_q;
    band_d   = band_q;
    bias_d   = bias_q;
    widx_d   = widx_q;
    err_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if ((cfg_width < K_DIM) || (cfg_height < K_DIM)) begin
            err_d = 1'b1;
          end else begin
            width_d  = cfg_width;
            height_d = cfg_height;
            bias_d   = cfg_bias;
            widx_d   = '0;
            col_d    = '0;
            band_d   = '0;
            state_d  = S_LOAD_W;
          end
        end
      end
      S_LOAD_W: begin
        if (w_fire) begin
          widx_d = widx_q + 1'b1;
          if (widx_q == W_LAST) begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (col_fire) begin
          if (col_q == width_q - 1'b1) begin
            col_d = '0;
            if (band_q == height_q - K_DIM) begin
              state_d = S_DRAIN;
            end else begin
              band_d = band_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if ((inflight_q == '0) && (fcnt_q == '0)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    vpipe_d[0] = pipe_in;
    for (int i = 1; i < DP_LATENCY; i++) begin
      vpipe_d[i] = vpipe_q[i-1];
    end
    inflight_d = inflight_q + CNT_W'(pipe_in) - CNT_W'(push);
    fcnt_d     = fcnt_q + CNT_W'(push) - CNT_W'(pop);

    wptr_d = wptr_q;
    rptr_d = rptr_q;
    mem_d  = mem_q;
    if (push) begin
      mem_d[wptr_q] = dp_result;
      wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      width_q    <= '0;
      height_q   <= '0;
      col_q      <= '0;
      band_q     <= '0;
      bias_q     <= '0;
      widx_q     <= '0;
      err_q      <= 1'b0;
      vpipe_q    <= '0;
      inflight_q <= '0;
      fcnt_q     <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      mem_q      <= '{default: '0};
    end else begin
      state_q    <= state_d;
      width_q    <= width_d;
      height_q   <= height_d;
      col_q      <= col_d;
      band_q     <= band_d;
      bias_q     <= bias_d;
      widx_q     <= widx_d;
      err_q      <= err_d;
      vpipe_q    <= vpipe_d;
      inflight_q <= inflight_d;
      fcnt_q     <= fcnt_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      mem_q      <= mem_d;
    end
  end

endmodule

// File: tb/tb_conv_controller.sv
// Scoreboard bench for conv_controller: stimulus pushes expected results,
// a negedge monitor pops and compares them as the FIFO presents them.
module tb_conv_controller;
  localparam int K     = 5;
  localparam int DW    = 16;
  localparam int DIMW  = 10;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [DIMW-1:0] cfg_width, cfg_height;
  logic [DW-1:0]   cfg_bias;
  logic            busy, done, err;
  logic            w_valid;
  logic [DW-1:0]   w_data;
  logic            w_ready;
  logic            col_valid, col_ready;
  logic            dp_weight_write;
  logic [4:0]      dp_weight_addr;
  logic [DW-1:0]   dp_weight_data;
  logic            dp_shift, dp_row_start;
  logic [DW-1:0]   dp_bias, dp_result;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic            out_ready;

  conv_controller #(
    .KERNEL_SIZE(K), .DATA_WIDTH(DW), .DIM_WIDTH(DIMW), .DP_LATENCY(LAT), .OUT_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_bias(cfg_bias),
    .busy(busy), .done(done), .err(err),
    .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
    .col_valid(col_valid), .col_ready(col_ready),
    .dp_weight_write(dp_weight_write), .dp_weight_addr(dp_weight_addr),
    .dp_weight_data(dp_weight_data),
    .dp_shift(dp_shift), .dp_row_start(dp_row_start), .dp_bias(dp_bias),
    .dp_result(dp_result),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Datapath stand-in: result for the n-th shift appears LAT cycles later.
  bit          const_mode = 1'b1;
  int          dut_shift_total = 0;
  logic [DW-1:0] dpp [LAT];
  always @(posedge clk) begin
    dpp[0] <= dp_shift ? (const_mode ? 16'h3200 : 16'h1000 + 16'(dut_shift_total)) : 16'hdead;
    for (int i = 1; i < LAT; i++) dpp[i] <= dpp[i-1];
    if (dp_shift) dut_shift_total <= dut_shift_total + 1;
  end
  assign dp_result = dpp[LAT-1];

  logic [DW-1:0] expq[$];
  int wr_cnt = 0, sh_frame = 0, shifts = 0, rowstarts = 0, outs = 0;
  int done_cnt = 0, err_cnt = 0, cur_w = 5;

  always @(negedge clk) begin
    if (!busy) sh_frame = 0;
    if (dp_weight_write) begin
      chk("w_addr", longint'(dp_weight_addr), longint'(wr_cnt % 25));
      chk("w_data", longint'(dp_weight_data), longint'(w_data));
      wr_cnt++;
    end
    if (dp_shift) begin
      chk("row_start", longint'(dp_row_start), longint'((sh_frame % cur_w) == 0));
      sh_frame++;
      shifts++;
      if (dp_row_start) rowstarts++;
    end
    if (out_valid && out_ready) begin
      if (expq.size() == 0) begin
        n_total++;
        $display("FAIL out_unexpected: got %0h expected none", out_data);
      end else begin
        chk("out_data", longint'(out_data), longint'(expq.pop_front()));
      end
      outs++;
    end
    if (done) done_cnt++;
    if (err) err_cnt++;
  end

  int acc_total = 0;
  int acc_frame = 0;
  bit cols_done;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input int w, input int h, input logic [DW-1:0] b);
    cfg_width  = DIMW'(w);
    cfg_height = DIMW'(h);
    cfg_bias   = b;
    cur_w      = w;
    acc_frame  = 0;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic load_weights(input bit gaps);
    chk("load_col_ready", longint'(col_ready), 0);
    for (int i = 0; i < 25; i++) begin
      int n;
      if (i == 24) chk("pre_last_w_ready", longint'(w_ready), 1);
      w_valid = 1'b1;
      w_data  = gaps ? 16'h0100 + 16'(i) : 16'h0100;
      n = 0;
      @(negedge clk);
      while (!w_ready && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (!w_ready) begin
        chk("w_timeout", 0, 1);
        w_valid = 1'b0;
        return;
      end
      tick();
      w_valid = 1'b0;
      if (gaps) tick();
    end
    chk("load_exit_w_ready", longint'(w_ready), 0);
  endtask

  task automatic send_cols(input int ncols, input int w);
    for (int c = 0; c < ncols; c++) begin
      int n;
      col_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!col_ready && n < 2000) begin
        @(negedge clk);
        n++;
      end
      if (!col_ready) begin
        chk("col_timeout", 0, 1);
        col_valid = 1'b0;
        return;
      end
      if ((acc_frame % w) >= K - 1)
        expq.push_back(const_mode ? 16'h3200 : 16'h1000 + 16'(acc_total));
      acc_total++;
      acc_frame++;
      tick();
    end
    col_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 2000);
    chk("done_seen", longint'(done), 1);
    @(negedge clk);
    chk("done_one_cycle", longint'(done), 0);
    chk("busy_after_done", longint'(busy), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int w, input int h, input logic [DW-1:0] b,
                           input bit gaps, input bit cm);
    int d0, o0, s0, r0, w0;
    const_mode = cm;
    d0 = done_cnt; o0 = outs; s0 = shifts; r0 = rowstarts; w0 = wr_cnt;
    start_frame(w, h, b);
    chk("busy_after_start", longint'(busy), 1);
    load_weights(gaps);
    send_cols(w * (h - K + 1), w);
    wait_done();
    chk("frame_done_cnt", done_cnt - d0, 1);
    chk("frame_outputs", outs - o0, (w - K + 1) * (h - K + 1));
    chk("frame_shifts", shifts - s0, w * (h - K + 1));
    chk("frame_row_starts", rowstarts - r0, h - K + 1);
    chk("frame_weights", wr_cnt - w0, 25);
    chk("frame_queue_empty", expq.size(), 0);
    chk("frame_bias", longint'(dp_bias), longint'(b));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int d0, o0, e0, base, n;
    reset = 1'b1; start = 1'b0; cfg_width = '0; cfg_height = '0; cfg_bias = '0;
    w_valid = 1'b0; w_data = '0; col_valid = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    chk("rst_busy", longint'(busy), 0);
    chk("rst_w_ready", longint'(w_ready), 0);
    chk("rst_col_ready", longint'(col_ready), 0);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_dp_bias", longint'(dp_bias), 0);
    reset = 1'b0;
    tick();

    // 5x5 frame: single window result
    run_frame(5, 5, 16'h0000, 1'b0, 1'b1);

    // 8x6 frame with w_valid gaps
    run_frame(8, 6, 16'h0080, 1'b1, 1'b0);

    // backpressure: FIFO fills to depth, then drains in order
    const_mode = 1'b0;
    o0 = outs; d0 = done_cnt;
    start_frame(8, 6, 16'h0011);
    load_weights(1'b0);
    out_ready = 1'b0;
    base = acc_total;
    cols_done = 1'b0;
    fork
      begin
        send_cols(16, 8);
        cols_done = 1'b1;
      end
    join_none
    repeat (30) tick();
    chk("stall_col_ready", longint'(col_ready), 0);
    chk("stall_out_valid", longint'(out_valid), 1);
    chk("stall_accepted", acc_frame, 8);
    chk("stall_no_pop", outs - o0, 0);
    chk("stall_head", longint'(out_data), longint'(16'h1000 + 16'(base + 4)));
    out_ready = 1'b1;
    n = 0;
    while (!cols_done && n < 2000) begin
      tick();
      n++;
    end
    chk("stall_cols_done", longint'(cols_done), 1);
    wait_done();
    chk("stall_outputs", outs - o0, 8);
    chk("stall_done_cnt", done_cnt - d0, 1);
    chk("stall_queue_empty", expq.size(), 0);

    // rejected starts
    e0 = err_cnt;
    cfg_width = 10'd4; cfg_height = 10'd5; start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("err_pulse", longint'(err), 1);
    chk("err_busy", longint'(busy), 0);
    chk("err_w_ready", longint'(w_ready), 0);
    @(negedge clk);
    chk("err_one_cycle", longint'(err), 0);
    tick();
    cfg_width = 10'd6; cfg_height = 10'd4; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("err_count", err_cnt - e0, 2);
    chk("err_still_idle", longint'(w_ready), 0);

    // async reset mid-RUN
    const_mode = 1'b1;
    d0 = done_cnt;
    start_frame(5, 5, 16'h0040);
    load_weights(1'b0);
    send_cols(3, 5);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_busy", longint'(busy), 0);
    chk("midrst_col_ready", longint'(col_ready), 0);
    chk("midrst_out_valid", longint'(out_valid), 0);
    chk("midrst_dp_bias", longint'(dp_bias), 0);
    chk("midrst_done", longint'(done), 0);
    tick();
    reset = 1'b0;
    repeat (5) tick();
    chk("midrst_no_done", done_cnt - d0, 0);
    run_frame(5, 5, 16'h0000, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
